// File: rtl/mem_stage.sv
// Data-memory pipeline stage: bus handshake FSM, store lane steering, load extract, M->W registers.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        StallM,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        BusErrW,
    output logic        MisalignW
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_next;
    logic [CW-1:0] r_cnt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;

    logic        w_byte, w_half, w_mis, w_access, w_timeout;
    logic [3:0]  w_be_m;
    logic [31:0] w_wdata_m, w_load;
    logic [2:0]  w_sel_f3;
    logic [1:0]  w_sel_lo;
    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign w_byte = (Funct3M[1:0] == 2'b00);
    assign w_half = (Funct3M[1:0] == 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_mis = (MemReadM | MemWriteM) &
                   ((w_half & ALUResultM[0]) | (~w_byte & ~w_half & (|ALUResultM[1:0])));
`else
    assign w_mis = 1'b0;
`endif

    assign w_access  = (MemReadM | MemWriteM) & ~w_mis;
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(WAIT_MAX)) && !dmem_ready;

    always_comb begin
        w_be_m    = 4'hF;
        w_wdata_m = WriteDataM;
        if (MemWriteM) begin
            if (w_byte) begin
                w_be_m    = 4'b0001 << ALUResultM[1:0];
                w_wdata_m = {4{WriteDataM[7:0]}};
            end else if (w_half) begin
                w_be_m    = 4'b0011 << {ALUResultM[1], 1'b0};
                w_wdata_m = {2{WriteDataM[15:0]}};
            end
        end
    end

    // While waiting the M inputs are stalled, but the lane info is taken from the held copy.
    assign w_sel_f3 = (r_state == S_WAIT) ? r_f3 : Funct3M;
    assign w_sel_lo = (r_state == S_WAIT) ? r_lo : ALUResultM[1:0];

    always_comb begin
        w_b = dmem_rdata[7:0];
        case (w_sel_lo)
            2'd1:    w_b = dmem_rdata[15:8];
            2'd2:    w_b = dmem_rdata[23:16];
            2'd3:    w_b = dmem_rdata[31:24];
            default: w_b = dmem_rdata[7:0];
        endcase
        w_h = w_sel_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (w_sel_f3)
            3'b000:  w_load = {{24{w_b[7]}}, w_b};
            3'b001:  w_load = {{16{w_h[15]}}, w_h};
            3'b100:  w_load = {24'h0, w_b};
            3'b101:  w_load = {16'h0, w_h};
            default: w_load = dmem_rdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = {ALUResultM[31:2], 2'b00};
        dmem_wdata   = w_wdata_m;
        dmem_be      = w_be_m;
        StallM       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    dmem_req = 1'b1;
                    dmem_we  = MemWriteM;
                    if (!dmem_ready) begin
                        StallM       = 1'b1;
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                dmem_we    = r_we;
                dmem_addr  = r_addr;
                dmem_wdata = r_wdata;
                dmem_be    = r_be;
                dmem_req   = ~w_timeout;
                StallM     = ~dmem_ready & ~w_timeout;
                if (dmem_ready || w_timeout)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (rst) begin
            dmem_req = 1'b0;
            StallM   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_f3    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE) begin
                r_cnt   <= '0;
                r_we    <= MemWriteM;
                r_addr  <= {ALUResultM[31:2], 2'b00};
                r_wdata <= w_wdata_m;
                r_be    <= w_be_m;
                r_f3    <= Funct3M;
                r_lo    <= ALUResultM[1:0];
            end else if (w_state_next == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadDataW  <= '0;
            ALUResultW <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            BusErrW    <= 1'b0;
            MisalignW  <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            BusErrW   <= 1'b0;
            MisalignW <= 1'b0;
        end else begin
            ReadDataW  <= w_load;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            ResultSrcW <= ResultSrcM;
            RegWriteW  <= RegWriteM & ~w_timeout & ~w_mis;
            BusErrW    <= w_timeout;
            MisalignW  <= w_mis;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized transactions, reset corner cases.
module tb_mem_stage;

    localparam int WAIT_MAX = 15;
    localparam int unsigned T = WAIT_MAX + 1;  // cycle index (0 = request cycle) at which timeout fires

    logic        clk, rst;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        StallM;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        BusErrW, MisalignW;

    int n_checks = 0;
    int n_err    = 0;

    mem_stage #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .StallM(StallM), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .BusErrW(BusErrW),
        .MisalignW(MisalignW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        int unsigned lat;       // cycles until dmem_ready (0 = same cycle)
        logic        regw;
        logic [31:0] exp_rdw;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int unsigned exp_stall;
        logic        exp_berr, exp_mis;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input int unsigned lat,
                                input logic regw, input logic [31:0] exp_rdw,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                input int unsigned exp_stall, input logic exp_berr,
                                input logic exp_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.lat = lat; v.regw = regw; v.exp_rdw = exp_rdw; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_stall = exp_stall; v.exp_berr = exp_berr;
        v.exp_mis = exp_mis;
        return v;
    endfunction

    // Reference model: derives expectations from access size/sign rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        int unsigned size, sh, lo;
        logic [31:0] mask, val;
        logic        acc;
        lo   = int'(v.addr & 32'd3);
        size = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        v.exp_mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        if ((v.rd || v.wr) && ((size == 2 && lo % 2 == 1) || (size == 4 && lo != 0)))
            v.exp_mis = 1'b1;
`endif
        v.exp_be = 4'hF;
        v.exp_wdata = v.wd;
        if (v.wr && size == 1) begin
            v.exp_be = 4'(1 << lo);
            v.exp_wdata = (v.wd & 32'hFF) * 32'h01010101;
        end else if (v.wr && size == 2) begin
            v.exp_be = 4'(3 << (2 * (lo / 2)));
            v.exp_wdata = (v.wd & 32'hFFFF) * 32'h00010001;
        end
        sh   = (size == 1) ? 8 * lo : (size == 2) ? 16 * (lo / 2) : 0;
        mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 1);
        val  = (v.rdata >> sh) & mask;
        if (size < 4 && v.f3[2] == 1'b0 && val[8 * size - 1])
            val = val | ~mask;
        v.exp_rdw = val;
        acc = (v.rd || v.wr) && !v.exp_mis;
        v.exp_stall = !acc ? 0 : (v.lat <= T) ? v.lat : T;
        v.exp_berr  = acc && (v.lat > T);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] pc;
        logic [4:0]  rdn;
        logic [1:0]  rs;
        logic        acc, req_exp;
        pc  = $urandom;
        rdn = 5'($urandom);
        rs  = 2'($urandom);
        acc = (v.rd || v.wr) && !v.exp_mis;
        ALUResultM = v.addr;  WriteDataM = v.wd;  PCPlus4M = pc;  RdM = rdn;
        RegWriteM  = v.regw;  ResultSrcM = rs;    MemReadM = v.rd; MemWriteM = v.wr;
        Funct3M    = v.f3;    dmem_rdata = v.rdata; dmem_ready = (v.lat == 0);
        for (int unsigned k = 0; k <= v.exp_stall; k++) begin
            #1;
            chk({tag, " StallM"}, 32'(StallM), 32'(k < v.exp_stall));
            req_exp = acc && !(v.exp_berr && k == v.exp_stall);
            chk({tag, " dmem_req"}, 32'(dmem_req), 32'(req_exp));
            if (req_exp) begin
                chk({tag, " dmem_addr"}, dmem_addr, v.addr & 32'hFFFFFFFC);
                chk({tag, " dmem_we"}, 32'(dmem_we), 32'(v.wr));
                chk({tag, " dmem_be"}, 32'(dmem_be), 32'(v.exp_be));
                if (v.wr) chk({tag, " dmem_wdata"}, dmem_wdata, v.exp_wdata);
            end
            @(posedge clk);
            #1;
            if (k < v.exp_stall) begin
                chk({tag, " bubble RegWriteW"}, 32'(RegWriteW), 32'd0);
                chk({tag, " bubble BusErrW"}, 32'(BusErrW), 32'd0);
                dmem_ready = (k + 1 == v.lat);
            end else begin
                chk({tag, " RegWriteW"}, 32'(RegWriteW), 32'(v.regw && !v.exp_berr && !v.exp_mis));
                chk({tag, " BusErrW"}, 32'(BusErrW), 32'(v.exp_berr));
                chk({tag, " MisalignW"}, 32'(MisalignW), 32'(v.exp_mis));
                chk({tag, " ALUResultW"}, ALUResultW, v.addr);
                chk({tag, " PCPlus4W"}, PCPlus4W, pc);
                chk({tag, " RdW"}, 32'(RdW), 32'(rdn));
                chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'(rs));
                if (v.rd && !v.exp_berr && !v.exp_mis)
                    chk({tag, " ReadDataW"}, ReadDataW, v.exp_rdw);
            end
        end
        dmem_ready = 1'b0;
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, " dmem_req"}, 32'(dmem_req), 32'd0);
        chk({tag, " StallM"}, 32'(StallM), 32'd0);
        chk({tag, " ReadDataW"}, ReadDataW, 32'd0);
        chk({tag, " ALUResultW"}, ALUResultW, 32'd0);
        chk({tag, " PCPlus4W"}, PCPlus4W, 32'd0);
        chk({tag, " RdW"}, 32'(RdW), 32'd0);
        chk({tag, " RegWriteW"}, 32'(RegWriteW), 32'd0);
        chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'd0);
        chk({tag, " BusErrW"}, 32'(BusErrW), 32'd0);
        chk({tag, " MisalignW"}, 32'(MisalignW), 32'd0);
    endtask

    initial begin
        vec_t v;
        //          rd   wr   f3    addr          wd            rdata         lat     regw exp_rdw       be     wdata         stall berr mis
        vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0,      1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        0,  1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 32'h103, 32'h0,        32'h80112233, 0,      1'b1, 32'hFFFFFF80, 4'hF, 32'h0,        0,  1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 3'd4, 32'h103, 32'h0,        32'h80112233, 0,      1'b1, 32'h00000080, 4'hF, 32'h0,        0,  1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0,        0,      1'b0, 32'h0,        4'hC, 32'hABCDABCD, 0,  1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 3'd0, 32'h301, 32'h1234565A, 32'h0,        1,      1'b0, 32'h0,        4'h2, 32'h5A5A5A5A, 1,  1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 0,      1'b1, 32'hFFFF8001, 4'hF, 32'h0,        0,  1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 3'd5, 32'h100, 32'h0,        32'h80017FFF, 0,      1'b1, 32'h00007FFF, 4'hF, 32'h0,        0,  1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h040, 32'h0,        32'h12345678, 3,      1'b1, 32'h12345678, 4'hF, 32'h0,        3,  1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h044, 32'h0,        32'h0BADF00D, 1000,   1'b1, 32'h0,        4'hF, 32'h0,        16, 1'b1, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h048, 32'h0,        32'hCAFEF00D, 16,     1'b1, 32'hCAFEF00D, 4'hF, 32'h0,        16, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 3'd2, 32'h5555, 32'h0,       32'h0,        0,      1'b1, 32'h0,        4'hF, 32'h0,        0,  1'b0, 1'b0));
`ifdef MEM_MISALIGN_CHECK_EN
        vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h101, 32'h0,        32'h11111111, 0,      1'b1, 32'h0,        4'hF, 32'h0,        0,  1'b0, 1'b1));
`endif

        rst = 1'b0;
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0; RegWriteM = 1'b0;
        ResultSrcM = '0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = '0;
        dmem_rdata = '0; dmem_ready = 1'b0;
        #1 rst = 1'b1;
        #1 chk_w_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // first access in the very first cycle out of reset
        for (int i = 0; i < vq.size(); i++)
            run_vec(vq[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            v.rd = 1'b0; v.wr = 1'b0;
            r = $urandom_range(0, 9);
            if (r < 5) v.rd = 1'b1; else if (r < 8) v.wr = 1'b1;
            v.f3    = v.wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.wd    = $urandom;
            v.rdata = $urandom;
            v.regw  = 1'($urandom);
            r = $urandom_range(0, 9);
            v.lat = (r < 7) ? $urandom_range(0, 3) : (r < 9) ? $urandom_range(4, T) : T + 5;
            run_vec(model(v), $sformatf("rnd%0d", i));
        end

        // reset while waiting abandons the access
        ALUResultM = 32'h80; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
        RegWriteM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("rstwait StallM", 32'(StallM), 32'd1);
        end
        rst = 1'b1;
        #1 chk_w_zero("rstwait");
        @(posedge clk);
        #1 rst = 1'b0;
        MemReadM = 1'b0; ALUResultM = 32'h1234; PCPlus4M = 32'h44; RdM = 5'd7;
        #1;
        chk("postrst dmem_req", 32'(dmem_req), 32'd0);
        chk("postrst StallM", 32'(StallM), 32'd0);
        @(posedge clk);
        #1;
        chk("postrst BusErrW", 32'(BusErrW), 32'd0);
        chk("postrst RegWriteW", 32'(RegWriteW), 32'd1);
        chk("postrst ALUResultW", ALUResultW, 32'h1234);
        chk("postrst RdW", 32'(RdW), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of cycles spent in WAIT before a bus timeout.
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, and reset is asynchronous and active-high.
REQ-003 SHALL have inputs ALUResultM (32, address or ALU result), WriteDataM (32, store data), PCPlus4M (32), RdM (5), RegWriteM (1), ResultSrcM (2), MemReadM (1), MemWriteM (1) and Funct3M (3, access size and sign).
REQ-004 SHALL have bus ports dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, 32), dmem_wdata (out, 32), dmem_be (out, 4), dmem_rdata (in, 32) and dmem_ready (in, 1).
REQ-005 SHALL have outputs StallM (1, hold the upstream stages), ReadDataW (32), ALUResultW (32), PCPlus4W (32), RdW (5), RegWriteW (1), ResultSrcW (2), BusErrW (1) and MisalignW (1).

Function
REQ-006 SHALL implement an FSM with states IDLE and WAIT.
REQ-007 In IDLE, a memory access (MemReadM or MemWriteM) SHALL assert dmem_req combinationally, with dmem_we = MemWriteM and dmem_addr = {ALUResultM[31:2], 2'b00}.
REQ-008 In IDLE, if dmem_ready = 1 in the same cycle as the request, the access SHALL complete with zero stall, and the W registers SHALL capture the result at the next clock edge.
REQ-009 In IDLE, a request without dmem_ready SHALL transition the FSM to WAIT.
REQ-010 In WAIT, the block SHALL:
- hold dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be stable;
- assert StallM;
- load a bubble into W each cycle (RegWriteW = 0, BusErrW = 0).
REQ-011 In WAIT, dmem_ready = 1 SHALL complete the access: StallM = 0 that cycle, W captures the result at the edge, and the FSM returns to IDLE.
REQ-012 A wait counter SHALL:
- clear on entry to WAIT;
- increment each WAIT cycle;
- when it reaches WAIT_MAX without dmem_ready, abort the access: deassert dmem_req, set StallM = 0, load W with RegWriteW = 0 and BusErrW = 1 for one cycle, and return to IDLE.
REQ-013 If dmem_ready and the timeout coincide, dmem_ready SHALL win and the access completes normally.
REQ-014 A cycle with no memory access SHALL pass straight through: StallM = 0, and W loads the M-stage inputs each clock.
REQ-015 Stores SHALL use:
- dmem_be = 0001<<a[1:0] for SB, 0011<<{a[1],0} for SH, 1111 for SW;
- dmem_wdata = WriteDataM[7:0] replicated x4 (SB), WriteDataM[15:0] replicated x2 (SH), WriteDataM (SW).
REQ-016 Loads SHALL drive dmem_be = 1111, and ReadDataW SHALL register the selected lane as follows:
- LB (000) and LH (001) sign-extended;
- LBU (100) and LHU (101) zero-extended;
- LW (010) the full word;
- lane selected by ALUResultM[1:0] for bytes and ALUResultM[1] for halfwords.
REQ-017 Funct3M values not listed in REQ-015 and REQ-016 SHALL be treated as word accesses.
REQ-018 ALUResultW, PCPlus4W, RdW and ResultSrcW SHALL register their M-stage counterparts on every non-stalled edge.
REQ-019 RegWriteW SHALL follow RegWriteM except for bubble, timeout and misaligned cycles, where it SHALL be 0.
REQ-020 The W registers SHALL give exactly one cycle of latency from access completion.

Reset
REQ-021 While rst is high, the block SHALL immediately:
- set the FSM to IDLE and clear the counter;
- clear all W outputs (RegWriteW, BusErrW and MisalignW included) to 0;
- set StallM = 0 and dmem_req = 0.
REQ-022 Reset asserted in WAIT SHALL abandon the pending access, with no completion and no error reported.
REQ-023 The first access SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-024 With macro MEM_MISALIGN_CHECK_EN defined:
- a misaligned access is a halfword with a[0] = 1 or a word with a[1:0] != 00;
- it SHALL issue no dmem_req and take no WAIT;
- W SHALL load RegWriteW = 0 and MisalignW = 1 for one cycle.
REQ-025 Without MEM_MISALIGN_CHECK_EN, MisalignW SHALL be tied 0, word accesses SHALL ignore a[1:0], and halfword accesses SHALL use a[1] only.

Verification
REQ-026 LW at 0x100 with dmem_ready held high and rdata 0xDEADBEEF -> StallM never asserted, ReadDataW = 0xDEADBEEF and RegWriteW = 1 one cycle later.
REQ-027 LB at 0x103 with rdata 0x80112233 -> ReadDataW = 0xFFFFFF80; the same access as LBU -> ReadDataW = 0x00000080.
REQ-028 SH at 0x202 with WriteDataM 0x0000ABCD -> dmem_be = 1100, dmem_wdata = 0xABCDABCD, dmem_we = 1.
REQ-029 LW with dmem_ready delayed 3 cycles -> StallM high 3 cycles, request held stable, 3 bubbles with RegWriteW = 0, then the valid result.
REQ-030 dmem_ready never asserted and WAIT_MAX = 15 -> StallM released after 15 WAIT cycles, BusErrW = 1 for one cycle, RegWriteW = 0.
REQ-031 rst asserted mid-WAIT -> dmem_req = 0, StallM = 0 and all W outputs 0 immediately; with MEM_MISALIGN_CHECK_EN, LW at 0x101 -> no dmem_req and MisalignW = 1.
